prv_trap_ctrl: RTL and testbench

Parametrised trap sequencer between the pipeline hazard unit and the privileged CSR file. Each cycle it collects exception, return and interrupt requests and prioritises them to one trap. It latches cause, EPC and trap value, waits for the pipeline to drain, then redirects fetch to the trap vector or return address. It generalises the fixed three-interrupt scheme to `N_EXT` external interrupt lines, adds vectored `xtvec` mode, and adds a bounded drain timeout.

---
 rtl/prv_trap_ctrl_pkg.sv | 81 ++++++++
 rtl/prv_trap_ctrl_if.sv | 76 +++++++
 rtl/prv_trap_ctrl_int_prio.sv | 56 +++++
 rtl/prv_trap_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_prv_trap_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prv_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// prv_trap_pkg
//   Shared types and constants for the privileged trap sequencer.
//   - trap_state_t : sequencer state (IDLE / DRAIN / REDIRECT)
//   - tvec_mode_t  : xtvec[1:0] mode encoding
//   - cause codes  : exception and interrupt codes
//   - exc_select() : fixed-priority exception decode
// ---------------------------------------------------------------------------
package prv_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_t;

  // Only VECTORED changes behaviour; both reserved encodings fall back to direct.
  typedef enum logic [1:0] {
    TVEC_DIRECT   = 2'd0,
    TVEC_VECTORED = 2'd1,
    TVEC_RSVD2    = 2'd2,
    TVEC_RSVD3    = 2'd3
  } tvec_mode_t;

  localparam int CODE_W      = 5;  // width of the cause code field
  localparam int EXC_N       = 9;  // number of exception request lines
  localparam int DRAIN_CNT_W = 8;  // wide enough for DRAIN_MAX up to 255

  typedef logic [CODE_W-1:0] code_t;

  // Exception cause codes
  localparam code_t EXC_INSN_MISALIGN  = 5'd0;
  localparam code_t EXC_INSN_FAULT     = 5'd1;
  localparam code_t EXC_ILLEGAL        = 5'd2;
  localparam code_t EXC_BREAKPOINT     = 5'd3;
  localparam code_t EXC_LOAD_MISALIGN  = 5'd4;
  localparam code_t EXC_LOAD_FAULT     = 5'd5;
  localparam code_t EXC_STORE_MISALIGN = 5'd6;
  localparam code_t EXC_STORE_FAULT    = 5'd7;
  localparam code_t EXC_ENV_CALL       = 5'd11;

  // Interrupt cause codes
  localparam code_t INT_SOFT  = 5'd3;
  localparam code_t INT_TIMER = 5'd7;
  localparam code_t INT_EXT   = 5'd11;

  // Bit positions of the packed exception request vector (MSB = highest priority).
  localparam int EXB_FAULT_INSN = 8;
  localparam int EXB_MAL_INSN   = 7;
  localparam int EXB_ILLEGAL    = 6;
  localparam int EXB_BREAKPOINT = 5;
  localparam int EXB_ENV        = 4;
  localparam int EXB_MAL_S      = 3;
  localparam int EXB_MAL_L      = 2;
  localparam int EXB_FAULT_S    = 1;
  localparam int EXB_FAULT_L    = 0;

  typedef struct packed {
    logic  valid;
    code_t code;
    logic  use_badaddr;  // tval takes the faulting address rather than zero
  } exc_sel_t;

  // Fixed-priority exception pick. The priority order is not the code order,
  // so the chain is written out explicitly.
  function automatic exc_sel_t exc_select(input logic [EXC_N-1:0] req);
    exc_sel_t sel;
    sel = '0;
    if (req[EXB_FAULT_INSN])      sel = '{1'b1, EXC_INSN_FAULT,     1'b1};
    else if (req[EXB_MAL_INSN])   sel = '{1'b1, EXC_INSN_MISALIGN,  1'b1};
    else if (req[EXB_ILLEGAL])    sel = '{1'b1, EXC_ILLEGAL,        1'b0};
    else if (req[EXB_BREAKPOINT]) sel = '{1'b1, EXC_BREAKPOINT,     1'b0};
    else if (req[EXB_ENV])        sel = '{1'b1, EXC_ENV_CALL,       1'b0};
    else if (req[EXB_MAL_S])      sel = '{1'b1, EXC_STORE_MISALIGN, 1'b1};
    else if (req[EXB_MAL_L])      sel = '{1'b1, EXC_LOAD_MISALIGN,  1'b1};
    else if (req[EXB_FAULT_S])    sel = '{1'b1, EXC_STORE_FAULT,    1'b1};
    else if (req[EXB_FAULT_L])    sel = '{1'b1, EXC_LOAD_FAULT,     1'b1};
    return sel;
  endfunction

endpackage

// File: rtl/prv_trap_ctrl_if.sv
// ---------------------------------------------------------------------------
// prv_trap_ctrl_if
//   Bundle between the hazard unit / CSR file (master) and the trap
//   sequencer (slave).
//   Requests  : exception lines, ret, interrupt lines, enables, epc, badaddr,
//               pipe_clear, xtvec, xepc_r
//   Responses : intr, insert_pc, priv_pc, trap_wr, ret_wr, cause, tval,
//               epc_o, ext_id, busy, timeout
// ---------------------------------------------------------------------------
interface prv_trap_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int N_EXT = 4
);

  // Exception requests
  logic             fault_insn;
  logic             mal_insn;
  logic             illegal_insn;
  logic             breakpoint;
  logic             env;
  logic             mal_s;
  logic             mal_l;
  logic             fault_s;
  logic             fault_l;

  // Return / pipeline status
  logic             ret;
  logic [XLEN-1:0]  epc;
  logic [XLEN-1:0]  badaddr;
  logic             pipe_clear;

  // Interrupts and enables
  logic             timer_int;
  logic             soft_int;
  logic [N_EXT-1:0] ext_int;
  logic             mstatus_ie;
  logic [N_EXT+1:0] ie_mask;

  // CSR inputs
  logic [XLEN-1:0]  xtvec;
  logic [XLEN-1:0]  xepc_r;

  // Outputs of the sequencer
  logic             intr;
  logic             insert_pc;
  logic [XLEN-1:0]  priv_pc;
  logic             trap_wr;
  logic             ret_wr;
  logic [XLEN-1:0]  cause;
  logic [XLEN-1:0]  tval;
  logic [XLEN-1:0]  epc_o;
  logic [3:0]       ext_id;
  logic             busy;
  logic             timeout;

  modport master (
    output fault_insn, mal_insn, illegal_insn, breakpoint, env,
           mal_s, mal_l, fault_s, fault_l,
           ret, epc, badaddr, pipe_clear,
           timer_int, soft_int, ext_int, mstatus_ie, ie_mask,
           xtvec, xepc_r,
    input  intr, insert_pc, priv_pc, trap_wr, ret_wr,
           cause, tval, epc_o, ext_id, busy, timeout
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, breakpoint, env,
           mal_s, mal_l, fault_s, fault_l,
           ret, epc, badaddr, pipe_clear,
           timer_int, soft_int, ext_int, mstatus_ie, ie_mask,
           xtvec, xepc_r,
    output intr, insert_pc, priv_pc, trap_wr, ret_wr,
           cause, tval, epc_o, ext_id, busy, timeout
  );

endinterface

// File: rtl/prv_trap_ctrl_int_prio.sv
// ---------------------------------------------------------------------------
// prv_int_prio
//   Combinational interrupt prioritiser.
//   req    in  N_EXT+2 : eligible requests; bit 0 timer, bit 1 soft,
//                        bits 2.. external lines
//   valid  out 1       : any eligible request
//   code   out 5       : winning interrupt code
//   ext_id out 4       : winning external line (0 when no external wins)
// ---------------------------------------------------------------------------
module prv_int_prio
  import prv_trap_pkg::*;
#(
  parameter int N_EXT = 4
) (
  input  logic [N_EXT+1:0] req,
  output logic             valid,
  output code_t            code,
  output logic [3:0]       ext_id
);

  logic [N_EXT-1:0] ext_req;
  logic             ext_any;
  logic [3:0]       ext_idx;

  assign ext_req = req[N_EXT+1:2];
  assign ext_any = |ext_req;

  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    ext_idx = '0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (ext_req[i]) begin
        ext_idx = 4'(i);
      end
    end
  end

  // External > soft > timer.
  always_comb begin
    valid  = 1'b1;
    code   = INT_EXT;
    ext_id = '0;
    if (ext_any) begin
      code   = INT_EXT;
      ext_id = ext_idx;
    end else if (req[1]) begin
      code = INT_SOFT;
    end else if (req[0]) begin
      code = INT_TIMER;
    end else begin
      valid = 1'b0;
      code  = '0;
    end
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// ---------------------------------------------------------------------------
// prv_trap_ctrl
//   Trap sequencer between the hazard unit and the privileged CSR file.
//   Picks one request per cycle (exception > ret > interrupt), latches
//   cause / tval / epc / redirect target, waits for the pipeline to drain
//   (bounded by DRAIN_MAX cycles) and then issues a one-cycle redirect.
//   Ports:
//     CLK  : clock, all state changes on the rising edge
//     RST  : synchronous active-high reset
//     bus  : prv_trap_ctrl_if.slave - request inputs and redirect/CSR outputs
// ---------------------------------------------------------------------------
module prv_trap_ctrl
  import prv_trap_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int N_EXT     = 4,
  parameter int DRAIN_MAX = 15
) (
  input logic            CLK,
  input logic            RST,
  prv_trap_ctrl_if.slave bus
);

  localparam int NSRC = N_EXT + 2;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LIMIT = DRAIN_CNT_W'(DRAIN_MAX);

  // -------------------------------------------------------------------------
  // State and latched trap record
  // -------------------------------------------------------------------------
  trap_state_t            state_reg,   state_next;
  logic [DRAIN_CNT_W-1:0] cnt_reg,     cnt_next;
  logic [XLEN-1:0]        pc_reg,      pc_next;
  logic [XLEN-1:0]        cause_reg,   cause_next;
  logic [XLEN-1:0]        tval_reg,    tval_next;
  logic [XLEN-1:0]        epc_reg,     epc_next;
  logic [3:0]             ext_id_reg,  ext_id_next;
  logic                   is_ret_reg,  is_ret_next;
  logic                   timeout_reg, timeout_next;
  logic                   insert_reg,  insert_next;
  logic                   trap_wr_reg, trap_wr_next;
  logic                   ret_wr_reg,  ret_wr_next;
  logic                   intr_take;

  // -------------------------------------------------------------------------
  // Exception decode
  // -------------------------------------------------------------------------
  logic [EXC_N-1:0] exc_req;
  exc_sel_t         exc_sel;

  assign exc_req = {bus.fault_insn, bus.mal_insn, bus.illegal_insn,
                    bus.breakpoint, bus.env, bus.mal_s, bus.mal_l,
                    bus.fault_s, bus.fault_l};
  assign exc_sel = exc_select(exc_req);

  // -------------------------------------------------------------------------
  // Interrupt eligibility and priority
  // -------------------------------------------------------------------------
  logic [NSRC-1:0] int_raw;
  logic [NSRC-1:0] int_elig;
  logic            int_valid;
  code_t           int_code;
  logic [3:0]      int_ext_id;

  assign int_raw = {bus.ext_int, bus.soft_int, bus.timer_int};

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_elig
    assign int_elig[gi] = bus.mstatus_ie & bus.ie_mask[gi] & int_raw[gi];
  end

  prv_int_prio #(
    .N_EXT (N_EXT)
  ) u_int_prio (
    .req    (int_elig),
    .valid  (int_valid),
    .code   (int_code),
    .ext_id (int_ext_id)
  );

  // -------------------------------------------------------------------------
  // Redirect target
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] vec_offset;
  logic [XLEN-1:0] int_target;
  tvec_mode_t      tvec_mode;

  assign tvec_base  = {bus.xtvec[XLEN-1:2], 2'b00};
  assign tvec_mode  = tvec_mode_t'(bus.xtvec[1:0]);
  assign vec_offset = {{(XLEN-CODE_W-2){1'b0}}, int_code, 2'b00};
  // Only interrupts are vectored; the sum wraps naturally at XLEN bits.
  assign int_target = (tvec_mode == TVEC_VECTORED) ? tvec_base + vec_offset
                                                   : tvec_base;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pc_next      = pc_reg;
    cause_next   = cause_reg;
    tval_next    = tval_reg;
    epc_next     = epc_reg;
    ext_id_next  = ext_id_reg;
    is_ret_next  = is_ret_reg;
    timeout_next = timeout_reg;
    insert_next  = 1'b0;
    trap_wr_next = 1'b0;
    ret_wr_next  = 1'b0;
    intr_take    = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (exc_sel.valid) begin
          cause_next  = {{(XLEN-CODE_W){1'b0}}, exc_sel.code};
          tval_next   = exc_sel.use_badaddr ? bus.badaddr : '0;
          pc_next     = tvec_base;
          ext_id_next = '0;
          is_ret_next = 1'b0;
        end else if (bus.ret) begin
          cause_next  = '0;
          tval_next   = '0;
          pc_next     = bus.xepc_r;
          ext_id_next = '0;
          is_ret_next = 1'b1;
        end else if (int_valid) begin
          cause_next  = {1'b1, {(XLEN-1-CODE_W){1'b0}}, int_code};
          tval_next   = '0;
          pc_next     = int_target;
          ext_id_next = int_ext_id;
          is_ret_next = 1'b0;
          intr_take   = 1'b1;
        end

        if (exc_sel.valid || bus.ret || int_valid) begin
          epc_next   = bus.epc;
          cnt_next   = '0;
          state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        cnt_next = cnt_reg + DRAIN_CNT_W'(1);
        // The compare uses the pre-increment count, so the longest wait is
        // DRAIN_MAX+1 DRAIN cycles, placing the redirect at N+2+DRAIN_MAX.
        if (bus.pipe_clear || (cnt_reg == DRAIN_LIMIT)) begin
          state_next   = ST_REDIRECT;
          insert_next  = 1'b1;
          trap_wr_next = ~is_ret_reg;
          ret_wr_next  = is_ret_reg;
          if (!bus.pipe_clear) begin
            timeout_next = 1'b1;
          end
        end
      end

      ST_REDIRECT: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pc_reg      <= '0;
      cause_reg   <= '0;
      tval_reg    <= '0;
      epc_reg     <= '0;
      ext_id_reg  <= '0;
      is_ret_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      insert_reg  <= 1'b0;
      trap_wr_reg <= 1'b0;
      ret_wr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pc_reg      <= pc_next;
      cause_reg   <= cause_next;
      tval_reg    <= tval_next;
      epc_reg     <= epc_next;
      ext_id_reg  <= ext_id_next;
      is_ret_reg  <= is_ret_next;
      timeout_reg <= timeout_next;
      insert_reg  <= insert_next;
      trap_wr_reg <= trap_wr_next;
      ret_wr_reg  <= ret_wr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // intr is the only combinational output; it is masked during reset so
  // every output reads 0 while RST is held.
  assign bus.intr      = intr_take & ~RST;
  assign bus.insert_pc = insert_reg;
  assign bus.priv_pc   = pc_reg;
  assign bus.trap_wr   = trap_wr_reg;
  assign bus.ret_wr    = ret_wr_reg;
  assign bus.cause     = cause_reg;
  assign bus.tval      = tval_reg;
  assign bus.epc_o     = epc_reg;
  assign bus.ext_id    = ext_id_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prv_trap_ctrl
//   Directed stimulus pushes the expected redirect record into a queue; a
//   negedge monitor pops and compares every time insert_pc is seen.
// ---------------------------------------------------------------------------
module tb_prv_trap_ctrl;

  localparam int XLEN      = 32;
  localparam int N_EXT     = 4;
  localparam int DRAIN_MAX = 15;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  prv_trap_ctrl_if #(.XLEN(XLEN), .N_EXT(N_EXT)) bus ();

  prv_trap_ctrl #(
    .XLEN      (XLEN),
    .N_EXT     (N_EXT),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int          id;
    int unsigned cyc;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] epc;
    logic [3:0]  ext_id;
    logic        trap_wr;
    logic        ret_wr;
    logic        timeout;
    logic        chk_csr;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Exception table: {fault_insn, mal_insn, illegal, bp, env, mal_s, mal_l, fault_s, fault_l}
  localparam logic [8:0] TAB_REQ [9] = '{
    9'b1_1100_0000, 9'b0_1100_0000, 9'b0_0110_0000,
    9'b0_0011_0000, 9'b0_0001_1000, 9'b0_0000_1100,
    9'b0_0000_0110, 9'b0_0000_0011, 9'b0_0000_0001
  };
  localparam logic [31:0] TAB_CODE [9] = '{1, 0, 2, 3, 11, 6, 4, 7, 5};
  localparam logic        TAB_BAD  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RST && (bus.trap_wr === 1'b1 || bus.ret_wr === 1'b1)) begin
      chk("strobe_with_insert", {31'd0, bus.insert_pc}, 32'd1);
    end
    if (!RST && bus.insert_pc === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect: priv_pc 0x%08h with no pending trap", bus.priv_pc);
      end else begin
        e = exp_q.pop_front();
        $display("redirect id=%0d cycle=%0d pc=0x%08h cause=0x%08h tval=0x%08h epc=0x%08h",
                 e.id, cyc, bus.priv_pc, bus.cause, bus.tval, bus.epc_o);
        chk("redirect_cycle", cyc, e.cyc);
        chk("priv_pc", bus.priv_pc, e.pc);
        chk("trap_wr", {31'd0, bus.trap_wr}, {31'd0, e.trap_wr});
        chk("ret_wr", {31'd0, bus.ret_wr}, {31'd0, e.ret_wr});
        chk("timeout", {31'd0, bus.timeout}, {31'd0, e.timeout});
        chk("ext_id", {28'd0, bus.ext_id}, {28'd0, e.ext_id});
        if (e.chk_csr) begin
          chk("cause", bus.cause, e.cause);
          chk("tval", bus.tval, e.tval);
          chk("epc_o", bus.epc_o, e.epc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    bus.fault_insn   = 1'b0; bus.mal_insn = 1'b0; bus.illegal_insn = 1'b0;
    bus.breakpoint   = 1'b0; bus.env      = 1'b0; bus.mal_s        = 1'b0;
    bus.mal_l        = 1'b0; bus.fault_s  = 1'b0; bus.fault_l      = 1'b0;
    bus.ret          = 1'b0; bus.timer_int = 1'b0; bus.soft_int    = 1'b0;
    bus.ext_int      = '0;
  endtask

  task automatic set_exc(input logic [8:0] v);
    bus.fault_insn = v[8]; bus.mal_insn = v[7]; bus.illegal_insn = v[6];
    bus.breakpoint = v[5]; bus.env      = v[4]; bus.mal_s        = v[3];
    bus.mal_l      = v[2]; bus.fault_s  = v[1]; bus.fault_l      = v[0];
  endtask

  task automatic expect_redirect(input int id, input int unsigned at,
                                 input logic [31:0] pc, input logic [31:0] cause,
                                 input logic [31:0] tval, input logic [31:0] epc,
                                 input logic [3:0] ext_id, input logic trap_wr,
                                 input logic ret_wr, input logic timeout,
                                 input logic chk_csr);
    exp_t e;
    e.id = id; e.cyc = at; e.pc = pc; e.cause = cause; e.tval = tval;
    e.epc = epc; e.ext_id = ext_id; e.trap_wr = trap_wr; e.ret_wr = ret_wr;
    e.timeout = timeout; e.chk_csr = chk_csr;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic exp_to;
    int   n;
    exp_to = 1'b0;
    clear_req();
    bus.epc = '0; bus.badaddr = '0; bus.pipe_clear = 1'b1;
    bus.mstatus_ie = 1'b0; bus.ie_mask = '0; bus.xtvec = '0; bus.xepc_r = '0;

    // Reset state
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_insert", {31'd0, bus.insert_pc}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    chk("rst_priv_pc", bus.priv_pc, 32'd0);
    chk("rst_cause", bus.cause, 32'd0);
    RST = 1'b0;
    tick();

    // Illegal instruction, minimum latency
    bus.xtvec = 32'h8000_0000; bus.badaddr = 32'h0000_DEAD; bus.epc = 32'h100;
    bus.illegal_insn = 1'b1;
    #1 chk("t1_intr", {31'd0, bus.intr}, 32'd0);
    expect_redirect(1, cyc + 2, 32'h8000_0000, 32'd2, 32'd0, 32'h100, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req();
    chk("t1_busy_drain", {31'd0, bus.busy}, 32'd1);
    chk("t1_pc_held", bus.priv_pc, 32'h8000_0000);
    wait_idle("t1_idle");

    // External interrupt, vectored, line 1 wins over line 2 and timer
    bus.mstatus_ie = 1'b1; bus.ie_mask = 6'h3F; bus.xtvec = 32'h8000_0001;
    bus.epc = 32'h300; bus.ext_int = 4'b0110; bus.timer_int = 1'b1;
    #1 chk("t2_intr_pulse", {31'd0, bus.intr}, 32'd1);
    expect_redirect(2, cyc + 2, 32'h8000_002C, 32'h8000_000B, 32'd0, 32'h300, 4'd1, 1, 0, exp_to, 1);
    tick();
    chk("t2_intr_drain", {31'd0, bus.intr}, 32'd0);
    clear_req();
    wait_idle("t2_idle");

    // Exception beats ret beats interrupt
    bus.xtvec = 32'h8000_0000; bus.badaddr = 32'h1234_5678; bus.epc = 32'h400;
    bus.xepc_r = 32'h2000; bus.mal_l = 1'b1; bus.ret = 1'b1; bus.soft_int = 1'b1;
    #1 chk("t3_intr", {31'd0, bus.intr}, 32'd0);
    expect_redirect(3, cyc + 2, 32'h8000_0000, 32'd4, 32'h1234_5678, 32'h400, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req();
    wait_idle("t3_idle");

    // Exception priority table; vectored xtvec must not affect exceptions
    bus.xtvec = 32'h0000_4001;
    for (int i = 0; i < 9; i++) begin
      bus.badaddr = 32'hA000_0000 + i;
      bus.epc     = 32'h1000 + 4 * i;
      set_exc(TAB_REQ[i]);
      expect_redirect(10 + i, cyc + 2, 32'h0000_4000, TAB_CODE[i],
                      TAB_BAD[i] ? 32'hA000_0000 + i : 32'd0,
                      32'h1000 + 4 * i, 4'd0, 1, 0, exp_to, 1);
      tick(); clear_req();
      wait_idle("tab_idle");
    end

    // Back-to-back: env arrives during DRAIN, is ignored, then accepted right after REDIRECT
    bus.xtvec = 32'h8000_0000; bus.epc = 32'h600; bus.breakpoint = 1'b1;
    n = int'(cyc);
    expect_redirect(20, n + 2, 32'h8000_0000, 32'd3, 32'd0, 32'h600, 4'd0, 1, 0, exp_to, 1);
    expect_redirect(21, n + 5, 32'h8000_0000, 32'd11, 32'd0, 32'h604, 4'd0, 1, 0, exp_to, 1);
    tick(); bus.breakpoint = 1'b0; bus.env = 1'b1; bus.epc = 32'h604;
    tick(); tick(); tick();
    bus.env = 1'b0;
    wait_idle("b2b_idle");

    // Soft over timer, externals masked, direct mode
    bus.mstatus_ie = 1'b1; bus.ie_mask = 6'b000011; bus.ext_int = 4'hF;
    bus.soft_int = 1'b1; bus.timer_int = 1'b1; bus.xtvec = 32'h4000_0000; bus.epc = 32'h310;
    #1 chk("t5_intr", {31'd0, bus.intr}, 32'd1);
    expect_redirect(30, cyc + 2, 32'h4000_0000, 32'h8000_0003, 32'd0, 32'h310, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req(); wait_idle("t5_idle");

    // Timer only, vectored: 0x1000 + 4*7
    bus.ie_mask = 6'b000001; bus.soft_int = 1'b1; bus.timer_int = 1'b1;
    bus.xtvec = 32'h0000_1001; bus.epc = 32'h320;
    #1 chk("t6_intr", {31'd0, bus.intr}, 32'd1);
    expect_redirect(31, cyc + 2, 32'h0000_101C, 32'h8000_0007, 32'd0, 32'h320, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req(); wait_idle("t6_idle");

    // Mode 3 treated as direct, highest external line
    bus.ie_mask = 6'h3F; bus.ext_int = 4'b1000; bus.xtvec = 32'h0000_2003; bus.epc = 32'h330;
    #1 chk("t7_intr", {31'd0, bus.intr}, 32'd1);
    expect_redirect(32, cyc + 2, 32'h0000_2000, 32'h8000_000B, 32'd0, 32'h330, 4'd3, 1, 0, exp_to, 1);
    tick(); clear_req(); wait_idle("t7_idle");

    // Mode 2 treated as direct, line 0 over timer
    bus.ext_int = 4'b0001; bus.timer_int = 1'b1; bus.xtvec = 32'h0000_3002; bus.epc = 32'h340;
    expect_redirect(33, cyc + 2, 32'h0000_3000, 32'h8000_000B, 32'd0, 32'h340, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req(); wait_idle("t8_idle");
    bus.mstatus_ie = 1'b0;

    // ret with pipeline never clearing: forced redirect after DRAIN_MAX
    bus.pipe_clear = 1'b0; bus.ret = 1'b1; bus.xepc_r = 32'h2000; bus.epc = 32'h500;
    exp_to = 1'b1;
    expect_redirect(40, cyc + 2 + DRAIN_MAX, 32'h2000, 32'd0, 32'd0, 32'h500, 4'd0, 0, 1, 1, 0);
    tick(); clear_req();
    chk("to_not_early", {31'd0, bus.timeout}, 32'd0);
    wait_idle("to_idle");
    bus.pipe_clear = 1'b1;
    chk("to_sticky", {31'd0, bus.timeout}, 32'd1);

    // timeout stays set across a later normal trap
    bus.xtvec = 32'h8000_0000; bus.badaddr = 32'h55; bus.epc = 32'h700; bus.fault_l = 1'b1;
    expect_redirect(41, cyc + 2, 32'h8000_0000, 32'd5, 32'h55, 32'h700, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req(); wait_idle("sticky_idle");

    // Reset while in DRAIN abandons the trap
    bus.pipe_clear = 1'b0; bus.epc = 32'h800; bus.illegal_insn = 1'b1;
    tick(); clear_req();
    tick();
    RST = 1'b1;
    tick();
    chk("rd_busy", {31'd0, bus.busy}, 32'd0);
    chk("rd_insert", {31'd0, bus.insert_pc}, 32'd0);
    chk("rd_trap_wr", {31'd0, bus.trap_wr}, 32'd0);
    chk("rd_timeout", {31'd0, bus.timeout}, 32'd0);
    chk("rd_priv_pc", bus.priv_pc, 32'd0);
    chk("rd_cause", bus.cause, 32'd0);
    chk("rd_tval", bus.tval, 32'd0);
    chk("rd_epc_o", bus.epc_o, 32'd0);
    RST = 1'b0;
    exp_to = 1'b0;
    bus.pipe_clear = 1'b1;
    repeat (20) tick();
    chk("rd_still_idle", {31'd0, bus.busy}, 32'd0);

    // Interrupts gated off: never leaves IDLE
    bus.mstatus_ie = 1'b0; bus.ie_mask = 6'h3F; bus.ext_int = 4'hF;
    bus.soft_int = 1'b1; bus.timer_int = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 15) begin
        bus.mstatus_ie = 1'b1;
        bus.ie_mask    = '0;
      end
      #1;
      chk("gated_busy", {31'd0, bus.busy}, 32'd0);
      chk("gated_intr", {31'd0, bus.intr}, 32'd0);
      tick();
    end
    clear_req();
    bus.mstatus_ie = 1'b0;

    // Normal operation after reset
    bus.xtvec = 32'h8000_0000; bus.badaddr = 32'h99; bus.epc = 32'h900; bus.mal_s = 1'b1;
    expect_redirect(50, cyc + 2, 32'h8000_0000, 32'd6, 32'h99, 32'h900, 4'd0, 1, 0, exp_to, 1);
    tick(); clear_req(); wait_idle("post_rst_idle");

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
